// File: rtl/loader_pkg.sv
// Shared definitions for the instruction stream loader: controller states and
// word geometry used by both the top level and the byte packer.
package loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_START   = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int INST_W         = 32;

endpackage

// File: rtl/byte_word_packer.sv
// Little-endian byte lane shifter. Each accepted byte lands in lane byte_idx,
// the first byte of a word in [7:0]. word_done flags the byte that completes a
// word, and word already carries that byte in the same cycle so the caller can
// register the finished word at the accepting edge.
module byte_word_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_data,
    output logic              word_done,
    output logic [INST_W-1:0] word
);

    logic [INST_W-1:0] lanes;
    logic [1:0]        byte_idx;

    // Lane storage and byte index; clear restarts the word at lane 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lanes    <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            lanes    <= '0;
            byte_idx <= '0;
        end else if (shift_en) begin
            lanes[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx                       <= byte_idx + 2'd1;
        end
    end

    // Present the word including the byte being accepted this cycle.
    always_comb begin
        word = lanes;
        if (shift_en) begin
            word[{byte_idx, 3'b000} +: 8] = byte_data;
        end
    end

    assign word_done = shift_en && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_stream_loader.sv
// Instruction-load bus master. Packs a valid/ready byte stream into 32-bit
// little-endian words, writes each word to instruction memory for one cycle,
// and pulses start after the requested number of words has been written.
//
// Byte handshake: a byte is transferred at a rising edge where byte_valid and
// byte_ready are both high; byte_ready is high only while collecting, the
// source may hold byte_valid low for any length of time, and byte_data only
// has to be stable while byte_valid is high.
module inst_stream_loader
    import loader_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4),
    parameter int                MAX_WORDS = 1024,
    localparam int               LEN_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [LEN_W-1:0]  load_words,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              enable_inst_in,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic [INST_W-1:0] INSTRUCTION,
    output logic              start,
    output logic              busy,
    output logic              err_len
);

    state_t            state;
    logic [LEN_W-1:0]  count;
    logic [ADDR_W-1:0] cur_addr;
    logic              shift_en;
    logic              pack_clear;
    logic              word_done;
    logic [INST_W-1:0] word;
    logic              len_ok;

    // A byte is taken only while collecting, and an abort in the same cycle
    // wins over the byte. The packer is held cleared whenever idle so every
    // load starts at lane 0.
    assign shift_en   = (state == ST_COLLECT) && byte_ready && byte_valid && !abort;
    assign pack_clear = (state == ST_IDLE);
    assign len_ok     = (load_words != '0) && (load_words <= LEN_W'(MAX_WORDS));

    byte_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (pack_clear),
        .shift_en  (shift_en),
        .byte_data (byte_data),
        .word_done (word_done),
        .word      (word)
    );

    // Load controller with registered outputs; reset beats abort beats normal flow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            count          <= '0;
            cur_addr       <= '0;
            byte_ready     <= 1'b0;
            enable_inst_in <= 1'b0;
            ADDRESS        <= '0;
            INSTRUCTION    <= '0;
            start          <= 1'b0;
            busy           <= 1'b0;
            err_len        <= 1'b0;
        end else begin
            err_len <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_req) begin
                        if (len_ok) begin
                            count      <= load_words;
                            cur_addr   <= BASE_ADDR;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                            state      <= ST_COLLECT;
                        end else begin
                            err_len <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (abort) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (word_done) begin
                        enable_inst_in <= 1'b1;
                        INSTRUCTION    <= word;
                        ADDRESS        <= cur_addr;
                        byte_ready     <= 1'b0;
                        state          <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // The write strobe has already been seen; an abort here
                    // only stops the remaining words.
                    enable_inst_in <= 1'b0;
                    count          <= count - LEN_W'(1);
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (count == LEN_W'(1)) begin
                        start <= 1'b1;
                        state <= ST_START;
                    end else begin
                        cur_addr   <= cur_addr + ADDR_STEP;
                        byte_ready <= 1'b1;
                        state      <= ST_COLLECT;
                    end
                end
                ST_START: begin
                    start <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_stream_loader.sv
// Bench for inst_stream_loader: two instances (base 0 and a base that wraps)
// share one stimulus stream and are compared every cycle against a load-level
// model, with literal expectations on the captured writes after directed tests.
module tb_inst_stream_loader;

    localparam int          LEN_W = 11;
    localparam int          MAXW  = 1024;
    localparam logic [31:0] BASE1 = 32'hFFFF_FFFC;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load_req;
    logic [LEN_W-1:0] load_words;
    logic             abort;
    logic             byte_valid;
    logic [7:0]       byte_data;

    logic        d0_ready, d0_en, d0_start, d0_busy, d0_err;
    logic [31:0] d0_addr, d0_inst;
    logic        d1_ready, d1_en, d1_start, d1_busy, d1_err;
    logic [31:0] d1_addr, d1_inst;

    int n_checks = 0;
    int n_fail   = 0;

    // captured DUT activity for literal checks
    logic [31:0] cap_addr0[$];
    logic [31:0] cap_addr1[$];
    logic [31:0] cap_data[$];
    int n_start = 0;
    int n_err   = 0;

    inst_stream_loader dut0 (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .load_words(load_words),
        .abort(abort), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(d0_ready), .enable_inst_in(d0_en), .ADDRESS(d0_addr),
        .INSTRUCTION(d0_inst), .start(d0_start), .busy(d0_busy), .err_len(d0_err)
    );

    inst_stream_loader #(.BASE_ADDR(BASE1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .load_words(load_words),
        .abort(abort), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(d1_ready), .enable_inst_in(d1_en), .ADDRESS(d1_addr),
        .INSTRUCTION(d1_inst), .start(d1_start), .busy(d1_busy), .err_len(d1_err)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + compare process ----------------
    // The model tracks a load as: words left, words written, bytes gathered.
    bit          m_loading, m_in_write, m_in_start;
    int          m_left, m_idx, m_nb;
    logic [31:0] m_word;
    logic        e_ready, e_busy, e_en, e_start, e_err;
    logic [31:0] e_addr0, e_addr1, e_inst;

    initial begin
        logic             s_rst, s_req, s_abort, s_valid;
        logic [7:0]       s_data;
        logic [LEN_W-1:0] s_words;
        m_loading = 0; m_in_write = 0; m_in_start = 0;
        m_left = 0; m_idx = 0; m_nb = 0; m_word = '0;
        forever begin
            @(posedge clk);
            s_rst = rst_n; s_req = load_req; s_abort = abort;
            s_valid = byte_valid; s_data = byte_data; s_words = load_words;
            if (!s_rst) begin
                m_loading = 0; m_in_write = 0; m_in_start = 0; m_nb = 0; m_word = '0;
                e_ready = 0; e_busy = 0; e_en = 0; e_start = 0; e_err = 0;
                e_addr0 = '0; e_addr1 = '0; e_inst = '0;
            end else begin
                e_err = 0;
                e_en  = 0;
                if (m_in_start) begin
                    m_in_start = 0; e_start = 0; e_busy = 0;
                end else if (m_in_write) begin
                    m_in_write = 0;
                    if (s_abort) begin
                        m_loading = 0; e_busy = 0;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_loading = 0; m_in_start = 1; e_start = 1;
                        end else begin
                            m_idx++; e_ready = 1;
                        end
                    end
                end else if (m_loading) begin
                    if (s_abort) begin
                        m_loading = 0; e_busy = 0; e_ready = 0;
                    end else if (s_valid) begin
                        m_word[8*m_nb +: 8] = s_data;
                        m_nb++;
                        if (m_nb == 4) begin
                            e_en = 1; e_inst = m_word; e_ready = 0;
                            e_addr0 = 32'(m_idx) * 32'd4;
                            e_addr1 = BASE1 + 32'(m_idx) * 32'd4;
                            m_in_write = 1; m_nb = 0; m_word = '0;
                        end
                    end
                end else if (s_req) begin
                    if (s_words >= 1 && s_words <= LEN_W'(MAXW)) begin
                        m_loading = 1; m_left = int'(s_words); m_idx = 0; m_nb = 0;
                        m_word = '0; e_busy = 1; e_ready = 1;
                    end else begin
                        e_err = 1;
                    end
                end
            end
            #1;
            check("d0_byte_ready", 64'(d0_ready), 64'(e_ready));
            check("d0_busy", 64'(d0_busy), 64'(e_busy));
            check("d0_enable", 64'(d0_en), 64'(e_en));
            check("d0_start", 64'(d0_start), 64'(e_start));
            check("d0_err_len", 64'(d0_err), 64'(e_err));
            check("d0_address", 64'(d0_addr), 64'(e_addr0));
            check("d0_instruction", 64'(d0_inst), 64'(e_inst));
            check("d1_byte_ready", 64'(d1_ready), 64'(e_ready));
            check("d1_busy", 64'(d1_busy), 64'(e_busy));
            check("d1_enable", 64'(d1_en), 64'(e_en));
            check("d1_start", 64'(d1_start), 64'(e_start));
            check("d1_err_len", 64'(d1_err), 64'(e_err));
            check("d1_address", 64'(d1_addr), 64'(e_addr1));
            check("d1_instruction", 64'(d1_inst), 64'(e_inst));
            if (d0_en) begin
                cap_addr0.push_back(d0_addr);
                cap_addr1.push_back(d1_addr);
                cap_data.push_back(d0_inst);
            end
            if (d0_start) n_start++;
            if (d0_err) n_err++;
        end
    end

    // ---------------- driver tasks (all act at the falling edge) ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_caps();
        cap_addr0.delete(); cap_addr1.delete(); cap_data.delete();
        n_start = 0; n_err = 0;
    endtask

    task automatic send_load(input int words);
        load_req = 1'b1; load_words = LEN_W'(words);
        @(negedge clk);
        load_req = 1'b0; load_words = LEN_W'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit done = 0;
        byte_valid = 1'b1; byte_data = b;
        for (int t = 0; t < 50 && !done; t++) begin
            if (d0_ready) done = 1;
            @(negedge clk);
        end
        byte_valid = 1'b0; byte_data = 8'($urandom);
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL byte_handshake_timeout: byte_ready stayed 0, required 1 within 50 cycles");
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_abort();
        byte_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] prog1[8];
        logic [7:0] prog2[4];
        prog1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        prog2 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        rst_n = 1'b0; load_req = 1'b0; load_words = '0; abort = 1'b0;
        byte_valid = 1'b0; byte_data = '0;
        idle(3);
        check("reset_busy", 64'(d0_busy), 64'd0);
        check("reset_byte_ready", 64'(d0_ready), 64'd0);
        check("reset_address", 64'(d1_addr), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // two words, back-to-back bytes
        clear_caps();
        send_load(2);
        foreach (prog1[i]) send_byte(prog1[i], 0);
        idle(4);
        check("t1_nwrites", 64'(cap_data.size()), 64'd2);
        if (cap_data.size() == 2) begin
            check("t1_data0", 64'(cap_data[0]), 64'h0000_0013);
            check("t1_addr0", 64'(cap_addr0[0]), 64'h0);
            check("t1_data1", 64'(cap_data[1]), 64'h0010_0093);
            check("t1_addr1", 64'(cap_addr0[1]), 64'h4);
            check("t1_wrap_addr0", 64'(cap_addr1[0]), 64'hFFFF_FFFC);
            check("t1_wrap_addr1", 64'(cap_addr1[1]), 64'h0);
        end
        check("t1_nstart", 64'(n_start), 64'd1);

        // one word, byte_valid every other cycle
        clear_caps();
        send_load(1);
        foreach (prog2[i]) send_byte(prog2[i], 1);
        idle(4);
        check("t2_nwrites", 64'(cap_data.size()), 64'd1);
        if (cap_data.size() == 1) begin
            check("t2_data", 64'(cap_data[0]), 64'hDEAD_BEEF);
            check("t2_addr", 64'(cap_addr0[0]), 64'h0);
        end

        // rejected lengths
        clear_caps();
        send_load(0);
        idle(2);
        send_load(MAXW + 1);
        idle(2);
        check("t3_nerr", 64'(n_err), 64'd2);
        check("t3_nwrites", 64'(cap_data.size()), 64'd0);

        // abort after two bytes of word 3, then a fresh one-word load
        clear_caps();
        send_load(4);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
        pulse_abort();
        check("t4_busy_after_abort", 64'(d0_busy), 64'd0);
        idle(3);
        check("t4_nwrites_aborted", 64'(cap_data.size()), 64'd2);
        check("t4_nstart_aborted", 64'(n_start), 64'd0);
        send_load(1);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        idle(4);
        check("t4_nwrites", 64'(cap_data.size()), 64'd3);
        if (cap_data.size() == 3) begin
            check("t4_data", 64'(cap_data[2]), 64'h4433_2211);
            check("t4_addr", 64'(cap_addr0[2]), 64'h0);
        end
        check("t4_nstart", 64'(n_start), 64'd1);

        // reset mid-collect
        clear_caps();
        send_load(2);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_busy_after_reset", 64'(d0_busy), 64'd0);
        check("t5_ready_after_reset", 64'(d0_ready), 64'd0);
        idle(3);
        check("t5_nwrites", 64'(cap_data.size()), 64'd0);
        check("t5_nstart", 64'(n_start), 64'd0);

        // load_req during a load is ignored
        clear_caps();
        send_load(2);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
        send_load(5);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
        idle(4);
        check("t6_nwrites", 64'(cap_data.size()), 64'd2);
        check("t6_nstart", 64'(n_start), 64'd1);
        if (cap_data.size() == 2) check("t6_addr1", 64'(cap_addr0[1]), 64'h4);

        // randomized loads, rejects and aborts
        for (int it = 0; it < 40; it++) begin
            int kind = $urandom_range(0, 9);
            if (kind == 0) begin
                send_load(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXW + 1, 2047));
                idle(2);
            end else begin
                int words = $urandom_range(1, 6);
                int nbytes = words * 4;
                bit do_abort = (kind <= 2);
                if (do_abort) nbytes = $urandom_range(0, words * 4 - 1);
                send_load(words);
                for (int b = 0; b < nbytes; b++) send_byte(8'($urandom), $urandom_range(0, 2));
                if (do_abort) pulse_abort();
                idle($urandom_range(3, 5));
            end
        end

        // maximum-length load
        clear_caps();
        send_load(MAXW);
        for (int b = 0; b < MAXW * 4; b++) send_byte(8'($urandom), 0);
        idle(4);
        check("t8_nwrites", 64'(cap_data.size()), 64'(MAXW));
        if (cap_data.size() == MAXW) check("t8_last_addr", 64'(cap_addr0[MAXW-1]), 64'd4092);
        check("t8_nstart", 64'(n_start), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
